// File: rtl/vec_alu_sequencer.sv
// -----------------------------------------------------------------------------
// vec_alu_sequencer
//
// Takes one 5-bit exec word per instruction, registers the decoded ALU control
// set and plays the instruction out to the lane ALUs as lane-group beats.
// Vector instructions produce one beat per group of LANES elements. Scalar
// instructions and func=1 instructions produce a single beat on lane 0.
// Division beats are spaced DIV_CYCLES apart. Illegal opcodes produce an err
// pulse, and no beats are issued for them.
//
// Optional build macro: VEC_MASK_EN
//   Adds a vmask input that is captured along with exec. Lane enables of vector
//   beats are ANDed with the mask. Beats whose lanes are all masked off are
//   skipped entirely.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   exec            [4]=func, [3:1]=opcode, [0]=immediate select
//   exec_valid      exec handshake valid
//   exec_ready      exec handshake ready (IDLE only)
//   opALU           ALU operation code
//   operALUe        scalar ALU operation
//   operALUve       vector-scalar ALU operation
//   operSum         vector-vector adder operation
//   muxSelect       operand B source: 0=register, 1=immediate
//   lane_en         per-lane enable of the current beat
//   elem_idx        index of the first element of the current beat
//   beat_valid      beat handshake valid
//   beat_ready      beat handshake ready from the lanes
//   beat_last       current beat is the final beat of the instruction
//   done            one-cycle pulse when the instruction completes
//   err             one-cycle pulse when an illegal opcode is rejected
//   vmask           (VEC_MASK_EN only) element mask, captured with exec
// -----------------------------------------------------------------------------
module vec_alu_sequencer #(
  parameter int VLEN       = 8,
  parameter int LANES      = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             exec,
  input  logic                   exec_valid,
  output logic                   exec_ready,
  output logic [2:0]             opALU,
  output logic                   operALUe,
  output logic                   operALUve,
  output logic                   operSum,
  output logic                   muxSelect,
  output logic [LANES-1:0]       lane_en,
  output logic [$clog2(VLEN):0]  elem_idx,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic                   beat_last,
  output logic                   done,
  output logic                   err
`ifdef VEC_MASK_EN
  ,
  input  logic [VLEN-1:0]        vmask
`endif
);

  localparam int EW = $clog2(VLEN) + 1;
  localparam int NB = (VLEN + LANES - 1) / LANES;
  localparam int CW = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, BEAT, WAIT, DONE} state_t;

  typedef struct packed {
    logic          found;
    logic [EW-1:0] idx;
  } beat_sel_t;

  // Lanes of beat k that hold real elements and are not masked off. Shifting in
  // zeros past VLEN gives the geometric bound for the partial last beat.
  function automatic logic [LANES-1:0] lanes_of(input logic [VLEN-1:0] m, input int k);
    logic [VLEN-1:0] sh;
    sh = m >> (k * LANES);
    return sh[LANES-1:0];
  endfunction

  // Returns the first beat at or after 'start' that has at least one live lane.
  function automatic beat_sel_t find_beat(input logic [VLEN-1:0] m, input int start);
    beat_sel_t r;
    r = '0;
    for (int j = 0; j < NB; j++) begin
      if (!r.found && j >= start && (|lanes_of(m, j))) begin
        r.found = 1'b1;
        r.idx   = EW'(j);
      end
    end
    return r;
  endfunction

  state_t          state, state_n;
  logic [EW-1:0]   k, k_n;
  logic [CW-1:0]   wait_cnt, wait_n;
  logic            is_div;
  logic            is_vec;
  logic [VLEN-1:0] vmask_in;
  logic [VLEN-1:0] vmask_q;

  logic [2:0]      dec_op;
  logic            dec_e, dec_ve, dec_sum, dec_illegal, dec_div, dec_vec;
  logic            accept;
  beat_sel_t       first_sel, next_sel;
  logic [LANES-1:0] cur_lanes;
  logic            cur_last;

`ifdef VEC_MASK_EN
  assign vmask_in = vmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vmask_q <= '0;
    else if (accept && !dec_illegal)
      vmask_q <= vmask_in;
  end
`else
  assign vmask_in = '1;
  assign vmask_q  = '1;
`endif

  // Instruction decode of the incoming exec word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    dec_op      = exec[3:1];
    dec_e       = 1'b0;
    dec_ve      = 1'b0;
    dec_sum     = 1'b0;
    dec_illegal = 1'b0;
    if (exec[4]) begin
      dec_op = 3'b111;
    end else begin
      unique case (exec[3:1])
        3'b000, 3'b010, 3'b011: dec_e       = 1'b1;
        3'b001, 3'b100, 3'b110: dec_ve      = 1'b1;
        3'b101:                 dec_sum     = 1'b1;
        default:                dec_illegal = 1'b1;
      endcase
    end
  end

  assign dec_div = !exec[4] && (exec[3:1] == 3'b110);
  assign dec_vec = dec_ve || dec_sum;
  assign accept  = (state == IDLE) && exec_ready && exec_valid;
  assign is_vec  = operALUve || operSum;

  assign first_sel = find_beat(vmask_in, 0);
  assign next_sel  = find_beat(vmask_q, int'(k) + 1);
  assign cur_lanes = is_vec ? lanes_of(vmask_q, int'(k)) : LANES'(1);
  assign cur_last  = !is_vec || !next_sel.found;

  always_comb begin
    state_n = state;
    k_n     = k;
    wait_n  = wait_cnt;
    unique case (state)
      IDLE: begin
        if (accept && !dec_illegal) begin
          if (!dec_vec) begin
            state_n = BEAT;
            k_n     = '0;
          end else if (first_sel.found) begin
            state_n = BEAT;
            k_n     = first_sel.idx;
          end else begin
            state_n = DONE;
          end
        end
      end
      BEAT: begin
        if (beat_ready) begin
          if (cur_last) begin
            state_n = DONE;
          end else begin
            k_n = next_sel.idx;
            if (is_div && (DIV_CYCLES > 1)) begin
              state_n = WAIT;
              wait_n  = CW'(DIV_CYCLES - 1);
            end
          end
        end
      end
      WAIT: begin
        if (wait_cnt <= CW'(1))
          state_n = BEAT;
        else
          wait_n = wait_cnt - CW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      wait_cnt   <= '0;
      exec_ready <= 1'b0;
      err        <= 1'b0;
      opALU      <= '0;
      operALUe   <= 1'b0;
      operALUve  <= 1'b0;
      operSum    <= 1'b0;
      muxSelect  <= 1'b0;
      is_div     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so that every flop
      // samples values from before the clock edge, regardless of statement order.
      state    <= state_n;
      k        <= k_n;
      wait_cnt <= wait_n;
      // exec_ready is registered. It stays low during reset and in the DONE
      // cycle, and it rises in the first cycle that is back in IDLE.
      exec_ready <= (state_n == IDLE);
      err        <= accept && dec_illegal;
      if (accept && !dec_illegal) begin
        opALU     <= dec_op;
        operALUe  <= dec_e;
        operALUve <= dec_ve;
        operSum   <= dec_sum;
        muxSelect <= exec[0];
        is_div    <= dec_div;
      end
    end
  end

  assign beat_valid = (state == BEAT);
  assign lane_en    = beat_valid ? cur_lanes : '0;
  assign elem_idx   = beat_valid ? EW'(int'(k) * LANES) : '0;
  assign beat_last  = beat_valid && cur_last;
  assign done       = (state == DONE);

endmodule
